node_integrator: RTL

- Consumes the per-node spring-force stream produced by the ideal-shape force stage: force_x/force_y beats plus a "forces done" strobe.
- Integrates each beat into node velocity and position with semi-implicit Euler, adding a constant gravity term to y.
- Owns the live node/velocity state that feeds back into the force stage.
- Writes updates into a shadow copy and commits all nodes at once, so the force stage sees a consistent snapshot for the whole pass.

---
 rtl/node_integrator.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/node_integrator.sv
// Semi-implicit Euler integrator for the node mesh: folds one force beat per cycle
// into a shadow copy of node state and commits every node at once when the pass completes.
module node_integrator #(
  parameter int unsigned NUM_NODES     = 10,
  parameter int unsigned POSITION_SIZE = 8,
  parameter int unsigned VELOCITY_SIZE = 8,
  parameter int unsigned FORCE_SIZE    = 8,
  parameter int unsigned DT_SHIFT      = 2,
  parameter int          GRAVITY       = -1
) (
  input  logic                                                    clk_in,
  input  logic                                                    rst_in,
  input  logic                                                    init_valid,
  input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]     init_nodes,
  input  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]     init_velocities,
  input  logic                                                    step_start,
  input  logic signed [FORCE_SIZE-1:0]                            force_x_in,
  input  logic signed [FORCE_SIZE-1:0]                            force_y_in,
  input  logic                                                    force_in_valid,
  input  logic                                                    forces_done_in,
  output logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]     nodes_out,
  output logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]     velocities_out,
  output logic                                                    busy,
  output logic                                                    step_done,
  output logic                                                    step_error
);

  localparam int unsigned CNT_W = $clog2(NUM_NODES + 1);
  localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  // Wide enough that no intermediate sum can wrap before saturation.
  localparam int unsigned SUM_W = POSITION_SIZE + VELOCITY_SIZE + FORCE_SIZE + 2;

  typedef logic signed [POSITION_SIZE-1:0] pos_t;
  typedef logic signed [VELOCITY_SIZE-1:0] vel_t;
  typedef logic signed [SUM_W-1:0]         sum_t;

  localparam sum_t V_MAX = SUM_W'((1 << (VELOCITY_SIZE - 1)) - 1);
  localparam sum_t V_MIN = SUM_W'(-(1 << (VELOCITY_SIZE - 1)));
  localparam sum_t P_MAX = SUM_W'((1 << (POSITION_SIZE - 1)) - 1);
  localparam sum_t P_MIN = SUM_W'(-(1 << (POSITION_SIZE - 1)));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMMIT
  } state_t;

  state_t                                              r_state;
  logic [CNT_W-1:0]                                    r_cnt;
  logic                                                r_ovf;
  logic                                                r_busy;
  logic                                                r_done;
  logic                                                r_err;
  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] r_live_pos;
  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] r_live_vel;
  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] r_sh_pos;
  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] r_sh_vel;

  logic             w_beat;
  logic             w_drop;
  logic [IDX_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;
  logic             w_pass_ok;
  sum_t             w_force   [2];
  vel_t             w_vel_new [2];
  pos_t             w_pos_new [2];

  function automatic vel_t sat_vel(input sum_t x);
    if (x > V_MAX) begin
      return VELOCITY_SIZE'(V_MAX);
    end else if (x < V_MIN) begin
      return VELOCITY_SIZE'(V_MIN);
    end
    return VELOCITY_SIZE'(x);
  endfunction

  function automatic pos_t sat_pos(input sum_t x);
    if (x > P_MAX) begin
      return POSITION_SIZE'(P_MAX);
    end else if (x < P_MIN) begin
      return POSITION_SIZE'(P_MIN);
    end
    return POSITION_SIZE'(x);
  endfunction

  // Beat acceptance and the velocity-then-position update for the addressed node.
  always_comb begin
    w_beat     = (r_state == S_ACCUM) && force_in_valid && (r_cnt < CNT_W'(NUM_NODES));
    w_drop     = (r_state == S_ACCUM) && force_in_valid && (r_cnt == CNT_W'(NUM_NODES));
    w_idx      = w_beat ? IDX_W'(r_cnt) : '0;
    w_cnt_next = r_cnt + CNT_W'(w_beat);
    w_ovf_next = r_ovf | w_drop;
    w_pass_ok  = (w_cnt_next == CNT_W'(NUM_NODES)) && !w_ovf_next;
    w_force[0] = SUM_W'($signed(force_x_in));
    w_force[1] = SUM_W'($signed(force_y_in)) + SUM_W'(GRAVITY);
    for (int d = 0; d < 2; d++) begin
      w_vel_new[d] = sat_vel(SUM_W'($signed(r_sh_vel[d][w_idx])) + (w_force[d] >>> DT_SHIFT));
      w_pos_new[d] = sat_pos(SUM_W'($signed(r_sh_pos[d][w_idx])) +
                             (SUM_W'(w_vel_new[d]) >>> DT_SHIFT));
    end
  end

  // Pass sequencing, shadow updates and the all-at-once commit to live state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_live_pos <= '0;
      r_live_vel <= '0;
      r_sh_pos   <= '0;
      r_sh_vel   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
          if (init_valid) begin
            r_live_pos <= init_nodes;
            r_live_vel <= init_velocities;
            r_sh_pos   <= init_nodes;
            r_sh_vel   <= init_velocities;
          end else if (step_start) begin
            r_state <= S_ACCUM;
            r_busy  <= 1'b1;
          end
        end
        S_ACCUM: begin
          r_cnt <= w_cnt_next;
          r_ovf <= w_ovf_next;
          if (w_beat) begin
            for (int d = 0; d < 2; d++) begin
              r_sh_vel[d][w_idx] <= w_vel_new[d];
              r_sh_pos[d][w_idx] <= w_pos_new[d];
            end
          end
          if (forces_done_in) begin
            if (w_pass_ok) begin
              r_state <= S_COMMIT;
            end else begin
              // Abandon the pass: the whole shadow reverts, overriding any same-cycle beat.
              r_sh_pos <= r_live_pos;
              r_sh_vel <= r_live_vel;
              r_err    <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        S_COMMIT: begin
          r_live_pos <= r_sh_pos;
          r_live_vel <= r_sh_vel;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign nodes_out      = r_live_pos;
  assign velocities_out = r_live_vel;
  assign busy           = r_busy;
  assign step_done      = r_done;
  assign step_error     = r_err;

endmodule
